// File: rtl/zigbee_tx_pkg.sv
// Shared types and constants for the Zigbee 2.4 GHz O-QPSK transmit path.
// Holds the symbol-to-chip PN table (bit 0 = first chip on air), the
// sequencer state encoding and the byte payload carried into the sequencer.
package zigbee_tx_pkg;

    localparam int unsigned CHIP_WIDTH = 32;
    localparam int unsigned SYM_WIDTH  = 4;
    localparam int unsigned BYTE_WIDTH = 8;
    localparam int unsigned CNT_WIDTH  = $clog2(CHIP_WIDTH);

    typedef logic [CHIP_WIDTH-1:0] chip_seq_t;
    typedef logic [SYM_WIDTH-1:0]  sym_t;
    typedef logic [CNT_WIDTH-1:0]  chip_cnt_t;

    // One PPDU byte plus its end-of-frame qualifier.
    typedef struct packed {
        logic                  last;
        logic [BYTE_WIDTH-1:0] data;
    } byte_beat_t;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SYM_LO,
        SYM_HI,
        DONE
    } seq_state_t;

    // 802.15.4 2.4 GHz PN sequences, indexed by symbol; bit n is chip c_n.
    localparam chip_seq_t CHIP_TABLE [16] = '{
        32'h744AC39B, 32'h44AC39B7, 32'h4AC39B74, 32'hAC39B744,
        32'hC39B744A, 32'h39B744AC, 32'h9B744AC3, 32'hB744AC39,
        32'hDEE06931, 32'hEE06931D, 32'hE06931DE, 32'h06931DEE,
        32'h6931DEE0, 32'h931DEE06, 32'h31DEE069, 32'h1DEE0693
    };

endpackage

// File: rtl/tx_byte_buffer.sv
// One-entry byte buffer in front of the chip sequencer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wdata/wvalid incoming byte beat and its valid
//   pop          sequencer has taken the held byte
//   frame_hold   next-cycle flag: a frame-final byte is still being sent
//   ready        registered: buffer can accept wdata this cycle
//   full, rdata  buffer occupancy and held beat
module tx_byte_buffer
    import zigbee_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  byte_beat_t wdata,
    input  logic       wvalid,
    input  logic       pop,
    input  logic       frame_hold,
    output logic       ready,
    output logic       full,
    output byte_beat_t rdata
);

    logic push;
    logic full_nxt;

    assign push = wvalid && ready;

    // Occupancy; push and pop are exclusive since ready implies empty.
    always_comb begin
        full_nxt = full;
        if (push) begin
            full_nxt = 1'b1;
        end else if (pop) begin
            full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            full  <= full_nxt;
            ready <= !full_nxt && !frame_hold;
            if (push) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/tx_chip_sequencer.sv
// Zigbee TX front controller: splits PPDU bytes into two symbols (low nibble
// first) and streams each symbol's 32 PN chips, one per clock, gap-free for
// the whole frame. A free-running phase flop mirrors the I/Q generator so
// chip 0 of every frame lands on an I slot (phase = 1).
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_byte, i_byte_valid, i_byte_last  byte handshake input
//   o_byte_ready                    sequencer accepts i_byte this cycle
//   o_chip, o_chip_valid            serial chip stream
//   o_frame_active                  first chip .. last chip of a frame
//   o_frame_done, o_underrun        one-cycle end-of-frame / abort pulses
module tx_chip_sequencer
    import zigbee_tx_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    input  logic                  i_byte_valid,
    input  logic                  i_byte_last,
    output logic                  o_byte_ready,
    output logic                  o_chip,
    output logic                  o_chip_valid,
    output logic                  o_frame_active,
    output logic                  o_frame_done,
    output logic                  o_underrun
);

    localparam chip_cnt_t CNT_MAX = CNT_WIDTH'(CHIP_WIDTH - 1);

    seq_state_t state, state_nxt;
    chip_cnt_t  cnt, cnt_nxt;
    logic       phase;
    sym_t       cur_hi;
    sym_t       sym_nxt;
    logic       last_held, last_held_nxt;
    logic       pop;
    logic       buf_full;
    byte_beat_t buf_beat;
    byte_beat_t in_beat;
    logic       chip_valid_nxt;
    logic       chip_nxt;
    logic       done_nxt;
    logic       underrun_nxt;

    assign in_beat = {i_byte_last, i_byte};

    tx_byte_buffer u_byte_buffer (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .wdata      (in_beat),
        .wvalid     (i_byte_valid),
        .pop        (pop),
        .frame_hold (last_held_nxt),
        .ready      (o_byte_ready),
        .full       (buf_full),
        .rdata      (buf_beat)
    );

    // Next state, buffer pop, and the values the output flops take next.
    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        last_held_nxt = last_held;
        done_nxt      = 1'b0;
        underrun_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (buf_full) begin
                    state_nxt = ALIGN;
                end
            end
            ALIGN: begin
                // Phase toggles every cycle, so phase = 0 now means I slot next.
                if (!phase) begin
                    state_nxt = SYM_LO;
                end
            end
            SYM_LO: begin
                if (cnt == CNT_MAX) begin
                    state_nxt     = SYM_HI;
                    pop           = 1'b1;
                    last_held_nxt = buf_beat.last;
                end
            end
            SYM_HI: begin
                if (cnt == CNT_MAX) begin
                    if (last_held) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (buf_full) begin
                        state_nxt = SYM_LO;
                    end else begin
                        state_nxt    = IDLE;
                        underrun_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt     = IDLE;
                last_held_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        chip_valid_nxt = (state_nxt == SYM_LO) || (state_nxt == SYM_HI);

        cnt_nxt = '0;
        if (chip_valid_nxt && ((state == SYM_LO) || (state == SYM_HI))) begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
        end

        // Low nibble is read straight from the buffer; the high nibble is
        // latched at pop, except on the pop cycle itself.
        sym_nxt = buf_beat.data[SYM_WIDTH-1:0];
        if (state_nxt == SYM_HI) begin
            sym_nxt = (state == SYM_LO) ? buf_beat.data[BYTE_WIDTH-1:SYM_WIDTH] : cur_hi;
        end

        chip_nxt = chip_valid_nxt && CHIP_TABLE[sym_nxt][cnt_nxt];
    end

    // State, counter, phase and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            phase          <= 1'b0;
            cur_hi         <= '0;
            last_held      <= 1'b0;
            o_chip         <= 1'b0;
            o_chip_valid   <= 1'b0;
            o_frame_active <= 1'b0;
            o_frame_done   <= 1'b0;
            o_underrun     <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            phase          <= !phase;
            last_held      <= last_held_nxt;
            o_chip         <= chip_nxt;
            o_chip_valid   <= chip_valid_nxt;
            o_frame_active <= chip_valid_nxt;
            o_frame_done   <= done_nxt;
            o_underrun     <= underrun_nxt;
            if (pop) begin
                cur_hi <= buf_beat.data[BYTE_WIDTH-1:SYM_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_tx_chip_sequencer.sv
// Testbench for tx_chip_sequencer: directed frames from a vector table,
// back-to-back prefetch, underrun, mid-frame reset and random frames, checked
// against the 802.15.4 chip sequences written out as chip strings.
module tb_tx_chip_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_last;
    logic       ready;
    logic       chip;
    logic       chip_valid;
    logic       frame_active;
    logic       frame_done;
    logic       underrun;

    always #5 clk = ~clk;

    tx_chip_sequencer dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_byte         (byte_in),
        .i_byte_valid   (byte_valid),
        .i_byte_last    (byte_last),
        .o_byte_ready   (ready),
        .o_chip         (chip),
        .o_chip_valid   (chip_valid),
        .o_frame_active (frame_active),
        .o_frame_done   (frame_done),
        .o_underrun     (underrun)
    );

    // Chips c0..c31 per symbol, as listed in the standard.
    string pn [16] = '{
        "11011001110000110101001000101110",
        "11101101100111000011010100100010",
        "00101110110110011100001101010010",
        "00100010111011011001110000110101",
        "01010010001011101101100111000011",
        "00110101001000101110110110011100",
        "11000011010100100010111011011001",
        "10011100001101010010001011101101",
        "10001100100101100000011101111011",
        "10111000110010010110000001110111",
        "01111011100011001001011000000111",
        "01110111101110001100100101100000",
        "00000111011110111000110010010110",
        "01100000011101111011100011001001",
        "10010110000001110111101110001100",
        "11001001011000000111011110111000"
    };

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [3:0] exp_lo;
        logic [3:0] exp_hi;
    } vec_t;

    vec_t vecs [5];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic tb_phase;

    // Monitor state
    bit         cap_chips [$];
    logic [3:0] exp_syms [$];
    int  phase_err, gap_err, fa_err, done_cnt, ur_cnt;
    int  first_cyc, last_valid_cyc, end_cyc;
    bit  last_valid = 1'b0;
    int  n_p0 = 0;
    int  n_p1 = 0;

    // Generator-side I/Q phase: I slot when 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_phase <= 1'b0;
        else        tb_phase <= ~tb_phase;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            last_valid = 1'b0;
        end else begin
            if (chip_valid) begin
                if (cap_chips.size() == 0) first_cyc = cyc;
                cap_chips.push_back(chip);
                if (((cap_chips.size() % 2) == 1) != tb_phase) phase_err++;
                if (!frame_active) fa_err++;
                last_valid_cyc = cyc;
            end else if (frame_active) begin
                fa_err++;
            end
            if (last_valid && !chip_valid && !frame_done && !underrun) gap_err++;
            if (frame_done) begin done_cnt++; end_cyc = cyc; end
            if (underrun)   begin ur_cnt++;   end_cyc = cyc; end
            last_valid = chip_valid;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        cap_chips.delete();
        exp_syms.delete();
        phase_err = 0; gap_err = 0; fa_err = 0; done_cnt = 0; ur_cnt = 0;
        first_cyc = -1; last_valid_cyc = -1; end_cyc = -1;
    endtask

    // Offer a byte after gap idle cycles; returns accept cycle and phase then.
    task automatic send_byte(input logic [7:0] b, input logic last, input int gap,
                             output int acc_c, output bit acc_p);
        int n = 0;
        @(posedge clk); #1;
        repeat (gap) begin @(posedge clk); #1; end
        byte_in = b; byte_last = last; byte_valid = 1'b1;
        while (!ready && n < 300) begin @(posedge clk); #1; n++; end
        if (!ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: byte %0h never accepted", b);
        end else begin
            @(posedge clk); #1;
        end
        acc_c = cyc; acc_p = tb_phase;
        byte_valid = 1'b0; byte_in = 8'h00; byte_last = 1'b0;
    endtask

    // Wait for frame_done or underrun, then check the end-of-frame cycles.
    task automatic wait_end(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(frame_done || underrun) && n < budget);
        if (!(frame_done || underrun)) begin
            n_tests++; n_fail++;
            $display("FAIL frame_end_timeout: no done/underrun within %0d cycles", budget);
        end else begin
            check("valid_low_at_end", 32'(chip_valid), 0);
            if (frame_done) check("ready_low_in_done", 32'(ready), 0);
            @(negedge clk);
            check("end_pulse_1cyc", 32'({frame_done, underrun}), 0);
            check("ready_after_end", 32'(ready), 1);
        end
    endtask

    task automatic check_frame(input string name, input bit exp_ur, input int acc_c, input bit acc_p);
        int    k = 0;
        int    mism = 0;
        string row;
        bit    expc;
        #2;
        check({name, "_len"}, cap_chips.size(), exp_syms.size() * 32);
        foreach (exp_syms[s]) begin
            row = pn[exp_syms[s]];
            for (int i = 0; i < 32; i++) begin
                expc = (row.getc(i) == 8'h31);
                if (k < cap_chips.size() && cap_chips[k] != expc) mism++;
                k++;
            end
        end
        check({name, "_chip_mismatches"}, mism, 0);
        check({name, "_iq_phase_errs"}, phase_err, 0);
        check({name, "_gap_errs"}, gap_err, 0);
        check({name, "_active_errs"}, fa_err, 0);
        check({name, "_done_cnt"}, done_cnt, exp_ur ? 0 : 1);
        check({name, "_underrun_cnt"}, ur_cnt, exp_ur ? 1 : 0);
        check({name, "_end_after_last_chip"}, end_cyc, last_valid_cyc + 1);
        check({name, "_latency"}, first_cyc - acc_c, acc_p ? 2 : 3);
    endtask

    initial begin : main
        int  ac, a1, a2;
        bit  ap, p1, p2;
        int  nb;
        logic [7:0] b;

        vecs[0] = '{8'h00, 0, 4'h0, 4'h0};
        vecs[1] = '{8'h5F, 1, 4'hF, 4'h5};
        vecs[2] = '{8'hC3, 2, 4'h3, 4'hC};
        vecs[3] = '{8'h9E, 3, 4'hE, 4'h9};
        vecs[4] = '{8'hB8, 4, 4'h8, 4'hB};

        rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; byte_last = 1'b0;
        clear_mon();
        #23;
        check("reset_outputs", 32'({ready, chip, chip_valid, frame_active, frame_done, underrun}), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(ready), 1);

        // Single-byte frames at varied start alignment.
        for (int v = 0; v < 5; v++) begin
            clear_mon();
            exp_syms.push_back(vecs[v].exp_lo);
            exp_syms.push_back(vecs[v].exp_hi);
            send_byte(vecs[v].data, 1'b1, vecs[v].gap, ac, ap);
            if (ap) n_p1++; else n_p0++;
            wait_end(200);
            check_frame($sformatf("vec%0d", v), 1'b0, ac, ap);
        end
        check("both_alignments_seen", 32'(n_p0 > 0 && n_p1 > 0), 1);

        // Back-to-back three-byte frame with prefetch during the high nibble.
        clear_mon();
        for (int i = 0; i < 6; i++) exp_syms.push_back(4'(i));
        send_byte(8'h10, 1'b0, 0, ac, ap);
        check("t2_ready_low_when_full", 32'(ready), 0);
        send_byte(8'h32, 1'b0, 0, a1, p1);
        send_byte(8'h54, 1'b1, 0, a2, p2);
        wait_end(400);
        check_frame("t2", 1'b0, ac, ap);
        check("t2_prefetch_byte1", a1, first_cyc + 33);
        check("t2_prefetch_byte2", a2, first_cyc + 97);

        // Underrun: no second byte, then a fresh frame.
        clear_mon();
        exp_syms.push_back(4'h7); exp_syms.push_back(4'hA);
        send_byte(8'hA7, 1'b0, 0, ac, ap);
        wait_end(300);
        check_frame("t3_underrun", 1'b1, ac, ap);
        clear_mon();
        exp_syms.push_back(4'h1); exp_syms.push_back(4'h2);
        send_byte(8'h21, 1'b1, 1, ac, ap);
        wait_end(200);
        check_frame("t3_restart", 1'b0, ac, ap);

        // Reset during the high nibble of a two-byte frame.
        clear_mon();
        send_byte(8'h66, 1'b0, 0, ac, ap);
        send_byte(8'h99, 1'b1, 0, a1, p1);
        repeat (5) @(negedge clk);
        check("t5_active_before_reset", 32'(chip_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_reset_outputs", 32'({ready, chip, chip_valid, frame_active, frame_done, underrun}), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        clear_mon();
        repeat (10) @(negedge clk);
        #1;
        check("t5_buffer_cleared_no_chips", cap_chips.size(), 0);
        check("t5_ready_after_reset", 32'(ready), 1);
        clear_mon();
        exp_syms.push_back(4'hC); exp_syms.push_back(4'h3);
        send_byte(8'h3C, 1'b1, 0, ac, ap);
        wait_end(200);
        check_frame("t5_after_reset", 1'b0, ac, ap);

        // Random frames with random valid gaps.
        for (int f = 0; f < 3; f++) begin
            clear_mon();
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
                exp_syms.push_back(b[3:0]);
                exp_syms.push_back(b[7:4]);
                if (k == 0) send_byte(b, 1'b0 || (nb == 1), $urandom_range(0, 3), ac, ap);
                else        send_byte(b, (k == nb - 1), $urandom_range(0, 10), a1, p1);
            end
            wait_end(400);
            check_frame($sformatf("rand%0d", f), 1'b0, ac, ap);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
